// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a valid/ready data bus with RV32I byte/half/word formatting.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        req_valid,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ABORT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic [1:0] off;
    size_t      sz;
    logic       uns;
  } lat_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t      state;
  lat_t        lat;
  logic [7:0]  cnt;
  logic        access, mis;
  size_t       sz;
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  assign access = (mem_read | mem_write) & ~flush;

  always_comb begin
    sz = SZ_W;
    case (funct3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    case (sz)
      SZ_B: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = ((sz == SZ_H) & addr[0]) | ((sz == SZ_W) & (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // A trapped misaligned access must not stall, or the trap unit could never flush it.
  assign misalign = (state == S_IDLE) & access & mis;
  assign stall    = ((state == S_IDLE) & access & ~mis) | (state == S_REQ) |
                    (state == S_WAIT) | ((state == S_ABORT) & access);

  function automatic logic [31:0] fmt(input logic [31:0] d, input lat_t l);
    logic [7:0]  b;
    logic [15:0] h;
    case (l.off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = l.off[1] ? d[31:16] : d[15:0];
    case (l.sz)
      SZ_B:    fmt = l.uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    fmt = l.uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: fmt = d;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lat        <= '0;
      cnt        <= '0;
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_be     <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        S_IDLE: if (access && !mis) begin
          req_valid <= 1'b1;
          req_we    <= ~mem_read;
          req_addr  <= {addr[31:2], 2'b00};
          req_be    <= be_n;
          req_wdata <= wd_n;
          lat       <= '{off: addr[1:0], sz: sz, uns: funct3[2]};
          state     <= S_REQ;
        end
        S_REQ: if (req_ready) begin
          // Accepted together with a flush: the response still has to be drained.
          req_valid <= 1'b0;
          cnt       <= '0;
          state     <= flush ? S_ABORT : S_WAIT;
        end else if (flush) begin
          req_valid <= 1'b0;
          state     <= S_IDLE;
        end
        S_WAIT: if (flush) begin
          cnt   <= '0;
          state <= rsp_valid ? S_IDLE : S_ABORT;
        end else if (rsp_valid) begin
          if (!req_we) begin
            load_data  <= fmt(rsp_rdata, lat);
            load_valid <= 1'b1;
          end
          state <= S_DONE;
        end else if (cnt == CNT_MAX) begin
          bus_err <= 1'b1;
          if (!req_we) load_data <= '0;
          state <= S_DONE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        S_ABORT: if (rsp_valid || cnt == CNT_MAX) state <= S_IDLE;
                 else cnt <= cnt + 8'd1;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, multi-cycle corner sequences, random vs model.
module tb_dmem_access_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, bus_err, misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .flush(flush), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err), .misalign(misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---- reference model, straight from the access-size rules ----
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int lane = int'(a[1:0]);
    if (f3[1:0] == 2'b00) return 4'(1 << lane);
    if (f3[1:0] == 2'b01) return 4'(3 << (2 * (lane / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int lane = int'(a[1:0]);
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      v = (d >> (8 * lane)) & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (f3[1:0] == 2'b01) begin
      v = (d >> (16 * (lane / 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = d;
    return v;
  endfunction

  // ---- transaction runner: drives the bus with the given delays, records what it saw ----
  int          r_nst;
  logic        r_lv, r_err, r_we, r_ok;
  logic [31:0] r_ld, r_addr, r_wd;
  logic [3:0]  r_be;

  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int rdy_dly, input int rsp_dly);
    int rc = 0, wc = 0;
    bit acc = 0, seen = 0, done = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; flush = 1'b0;
    r_nst = 0; r_ok = 0; r_lv = 0; r_err = 0; r_ld = '0;
    r_addr = '0; r_wd = '0; r_be = '0; r_we = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      rsp_valid = acc && (wc == rsp_dly);
      rsp_rdata = rsp_valid ? rdat : $urandom;
      if (acc) wc++;
      req_ready = 1'b0;
      if (req_valid) begin
        if (!seen) begin
          r_addr = req_addr; r_wd = req_wdata; r_be = req_be; r_we = req_we;
        end
        seen = 1;
        req_ready = (rc == rdy_dly);
        if (req_ready) acc = 1;
        rc++;
      end
      #1;
      if (stall) r_nst++;
      else begin
        r_lv = load_valid; r_err = bus_err; r_ld = load_data; r_ok = 1; done = 1;
      end
      @(posedge clk); #1;
    end
    mem_read = 0; mem_write = 0; req_ready = 0; rsp_valid = 0;
    if (!r_ok) chk("txn_completion_bound", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;
    logic [3:0]  be;
    logic [31:0] exp_wd, exp_ld;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] last_ld;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'h00000080};
    vecs[3] = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h00000080};
    vecs[4] = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h00000080};
    vecs[5] = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[6] = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h8001F234, 4'h3, 32'h0,        32'h0000F234};
    vecs[7] = '{1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 32'h0000F234};

    rst = 1'b1; mem_read = 0; mem_write = 0; flush = 0; funct3 = 0; addr = 0; wdata = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, req_valid}, 0);
    chk("rst_req_be", {28'b0, req_be}, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_flags", {29'b0, load_valid, bus_err, misalign}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed vectors, zero-wait bus
    foreach (vecs[i]) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rdat, 0, 0);
      chk($sformatf("vec%0d_stall_cycles", i), r_nst, 3);
      chk($sformatf("vec%0d_addr", i), r_addr, vecs[i].a & ~32'h3);
      chk($sformatf("vec%0d_be", i), {28'b0, r_be}, {28'b0, vecs[i].be});
      chk($sformatf("vec%0d_we", i), {31'b0, r_we}, {31'b0, vecs[i].wr});
      if (vecs[i].wr) chk($sformatf("vec%0d_wdata", i), r_wd, vecs[i].exp_wd);
      chk($sformatf("vec%0d_load_valid", i), {31'b0, r_lv}, {31'b0, vecs[i].rd});
      chk($sformatf("vec%0d_load_data", i), r_ld, vecs[i].exp_ld);
    end
    last_ld = 32'h0000F234;

    // timeout: ready after 5 cycles, no response ever
    run_txn(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 32'h0, 5, 1000);
    chk("to_stall_cycles", r_nst, 1 + 6 + TO);
    chk("to_bus_err", {31'b0, r_err}, 1);
    chk("to_load_valid", {31'b0, r_lv}, 0);
    chk("to_load_data", r_ld, 0);
    last_ld = 0;
    #1;
    chk("to_bus_err_pulse_1cyc", {31'b0, bus_err}, 0);
    @(posedge clk); #1;

    // flush in REQ before accept: request withdrawn
    mem_read = 1; funct3 = 3'b010; addr = 32'h240;
    @(posedge clk); #1;
    flush = 1;
    #1 chk("freq_stall", {31'b0, stall}, 1);
    @(posedge clk); #1;
    flush = 0; mem_read = 0;
    #1;
    chk("freq_req_valid", {31'b0, req_valid}, 0);
    chk("freq_stall_after", {31'b0, stall}, 0);
    @(posedge clk); #1;

    // flush in WAIT, response 2 cycles later, next LW already pending
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    req_ready = 1;
    @(posedge clk); #1;
    req_ready = 0; flush = 1; addr = 32'h400;
    @(posedge clk); #1;
    flush = 0;
    #1;
    chk("abort_stall", {31'b0, stall}, 1);
    chk("abort_load_valid", {31'b0, load_valid}, 0);
    @(posedge clk); #1;
    rsp_valid = 1; rsp_rdata = 32'h55555555;
    @(posedge clk); #1;
    rsp_valid = 0;
    #1;
    chk("abort_exit_load_valid", {31'b0, load_valid}, 0);
    chk("abort_exit_req_valid", {31'b0, req_valid}, 0);
    chk("abort_load_data_held", load_data, last_ld);
    run_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 0, 0);
    chk("post_abort_addr", r_addr, 32'h400);
    chk("post_abort_stall_cycles", r_nst, 3);
    chk("post_abort_load_data", r_ld, 32'h13579BDF);
    last_ld = 32'h13579BDF;

    // misaligned LW 0x101
`ifdef MISALIGN_TRAP_EN
    mem_read = 1; funct3 = 3'b010; addr = 32'h101;
    #1;
    chk("mis_pulse", {31'b0, misalign}, 1);
    chk("mis_stall", {31'b0, stall}, 0);
    @(posedge clk); #1;
    mem_read = 0;
    #1 chk("mis_no_req", {31'b0, req_valid}, 0);
    @(posedge clk); #1;
`else
    run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hA1B2C3D4, 0, 0);
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_be", {28'b0, r_be}, 32'hF);
    chk("mis_load_data", r_ld, 32'hA1B2C3D4);
    chk("mis_flag", {31'b0, misalign}, 0);
    last_ld = 32'hA1B2C3D4;
`endif

    // randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      logic        rd, wr, is_ld, to;
      logic [2:0]  f3;
      logic [31:0] a, wd, rdat;
      int          rdy, rsp, exp_nst;
      logic [2:0]  f3s[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      f3   = f3s[$urandom_range(0, 6)];
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a    = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
`endif
      wd   = $urandom;
      rdat = $urandom;
      rdy  = $urandom_range(0, 3);
      rsp  = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
      is_ld = rd;
      to    = (rsp >= TO);
      exp_nst = 1 + (rdy + 1) + (to ? TO : rsp + 1);
      run_txn(rd, wr, f3, a, wd, rdat, rdy, rsp);
      if (is_ld) last_ld = to ? 32'h0 : m_ld(f3, a, rdat);
      chk($sformatf("rnd%0d_stall_cycles", n), r_nst, exp_nst);
      chk($sformatf("rnd%0d_addr", n), r_addr, a & ~32'h3);
      chk($sformatf("rnd%0d_be", n), {28'b0, r_be}, {28'b0, m_be(f3, a)});
      chk($sformatf("rnd%0d_we", n), {31'b0, r_we}, {31'b0, ~is_ld});
      if (!is_ld) chk($sformatf("rnd%0d_wdata", n), r_wd, m_wd(f3, wd));
      chk($sformatf("rnd%0d_flags", n), {30'b0, r_lv, r_err}, {30'b0, is_ld & ~to, to});
      chk($sformatf("rnd%0d_load_data", n), r_ld, last_ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end
endmodule
